// File: rtl/dijkstra_scheduler_pkg.sv
// dijkstra_pkg: shared constants and types for the Dijkstra solver scheduler.
//   DEF_NODE_W    default node-id width
//   *_ADDR        CPU data-memory addresses used to hand a job to the solver
//                 and to snoop its result
//   state_e       scheduler FSM states
package dijkstra_pkg;

  localparam int DEF_NODE_W = 5;

  localparam logic [31:0] SP_ADDR   = 32'h0200_0000;
  localparam logic [31:0] EP_ADDR   = 32'h0200_0004;
  localparam logic [31:0] PATH_BASE = 32'h0200_0008;
  localparam logic [31:0] DONE_ADDR = 32'h0200_0088;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_SP,
    LOAD_EP,
    CPU_RST,
    RUN,
    STREAM
  } state_e;

endpackage

// File: rtl/dijkstra_scheduler_if.sv
// dijkstra_scheduler_if: CPU-side bus and path stream of the scheduler.
//   cpu_reset / cpu_ext_*          scheduler -> CPU (reset, external data write)
//   cpu_memwrite/dataadr/writedata CPU -> scheduler (snooped stores)
//   path_node/valid/last           scheduler -> path_mapping stream
//   path_ready                     path_mapping -> scheduler
// master = scheduler side, slave = CPU / path consumer side.
interface dijkstra_scheduler_if
  import dijkstra_pkg::*;
#(
  parameter int NODE_W = DEF_NODE_W
);

  logic              cpu_reset;
  logic              cpu_ext_memwrite;
  logic [31:0]       cpu_ext_dataadr;
  logic [31:0]       cpu_ext_writedata;
  logic              cpu_memwrite;
  logic [31:0]       cpu_dataadr;
  logic [31:0]       cpu_writedata;
  logic [NODE_W-1:0] path_node;
  logic              path_valid;
  logic              path_last;
  logic              path_ready;

  modport master (
    output cpu_reset, cpu_ext_memwrite, cpu_ext_dataadr, cpu_ext_writedata,
    output path_node, path_valid, path_last,
    input  cpu_memwrite, cpu_dataadr, cpu_writedata, path_ready
  );

  modport slave (
    input  cpu_reset, cpu_ext_memwrite, cpu_ext_dataadr, cpu_ext_writedata,
    input  path_node, path_valid, path_last,
    output cpu_memwrite, cpu_dataadr, cpu_writedata, path_ready
  );

endinterface

// File: rtl/dijkstra_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req       request vector
//   ptr       index with highest priority this round
//   grant     one-hot grant (zero when no request)
//   grant_id  index of the granted requester
//   grant_vld any request granted
module rr_arbiter
  import dijkstra_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_vld
);

  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    // Scan from ptr upward with wrap; the first asserted request wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!grant_vld && req[j]) begin
        grant_vld = 1'b1;
        grant[j]  = 1'b1;
        grant_id  = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/dijkstra_scheduler.sv
// dijkstra_scheduler: shares one RISC-V Dijkstra solver among NUM_REQ requesters.
// A round-robin grant latches the owner's start/end node, writes them into CPU
// data memory, pulses the CPU through reset, snoops the path the program
// stores, streams it out, then pulses req_done (or req_err) to the owner.
//   clk_50M, rst_n      clock, asynchronous active-low reset
//   req/req_sp/req_ep   level requests with per-requester start/end node slices
//   req_done/req_err    one-cycle completion / failure pulse on the owner bit
//   owner, busy         current job owner, scheduler not idle
//   bus                 CPU control/snoop and path stream (master modport)
module dijkstra_scheduler
  import dijkstra_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int NODE_W     = DEF_NODE_W,
  parameter int MAX_PATH   = 32,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 2_000_000,
  localparam int ID_W      = $clog2(NUM_REQ),
  localparam int IDX_W     = $clog2(MAX_PATH),
  localparam int LEN_W     = $clog2(MAX_PATH + 1)
) (
  input  logic                      clk_50M,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*NODE_W-1:0] req_sp,
  input  logic [NUM_REQ*NODE_W-1:0] req_ep,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        req_err,
  output logic [ID_W-1:0]           owner,
  output logic                      busy,
  dijkstra_scheduler_if.master      bus
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, owner_q;
  logic [NODE_W-1:0]   sp_q, ep_q;
  logic [31:0]         cnt_q;
  logic [LEN_W-1:0]    len_q;
  logic [IDX_W-1:0]    idx_q;
  logic [NUM_REQ-1:0]  done_q, err_q;
  logic [NODE_W-1:0]   path_buf [MAX_PATH];

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic                grant_vld;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req       (req),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_vld (grant_vld)
  );

  // Offset below PATH_BASE wraps to a huge value, so one unsigned compare
  // covers both window edges.
  logic [31:0] path_off;
  logic        win_wr, done_wr, len_ok, timeout_hit, rst_end, at_last;

  assign path_off    = bus.cpu_dataadr - PATH_BASE;
  assign win_wr      = (state_q == RUN) && bus.cpu_memwrite &&
                       (path_off < 32'(4 * MAX_PATH)) && (path_off[1:0] == 2'b00);
  assign done_wr     = (state_q == RUN) && bus.cpu_memwrite && (bus.cpu_dataadr == DONE_ADDR);
  assign len_ok      = (bus.cpu_writedata != 32'd0) && (bus.cpu_writedata <= 32'(MAX_PATH));
  assign timeout_hit = (cnt_q == 32'(TIMEOUT - 1));
  assign rst_end     = (cnt_q == 32'(RST_CYCLES - 1));
  assign at_last     = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));

  // State register
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = LOAD_SP;
      LOAD_SP: state_d = LOAD_EP;
      LOAD_EP: state_d = CPU_RST;
      CPU_RST: if (rst_end) state_d = RUN;
      RUN: begin
        if (done_wr)          state_d = len_ok ? STREAM : IDLE;
        else if (timeout_hit) state_d = IDLE;
      end
      STREAM:  if (bus.path_ready && at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.cpu_reset         = (state_q != RUN);
    bus.cpu_ext_memwrite  = (state_q == LOAD_SP) || (state_q == LOAD_EP);
    bus.cpu_ext_dataadr   = '0;
    bus.cpu_ext_writedata = '0;
    if (state_q == LOAD_SP) begin
      bus.cpu_ext_dataadr   = SP_ADDR;
      bus.cpu_ext_writedata = 32'(sp_q);
    end else if (state_q == LOAD_EP) begin
      bus.cpu_ext_dataadr   = EP_ADDR;
      bus.cpu_ext_writedata = 32'(ep_q);
    end
    bus.path_valid = (state_q == STREAM);
    bus.path_node  = (state_q == STREAM) ? path_buf[idx_q] : '0;
    bus.path_last  = (state_q == STREAM) && at_last;
    busy           = (state_q != IDLE);
    owner          = owner_q;
    req_done       = done_q;
    req_err        = err_q;
  end

  // Job bookkeeping: grant latch, counters, stream index, result pulses
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      owner_q  <= '0;
      sp_q     <= '0;
      ep_q     <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            owner_q  <= grant_id;
            sp_q     <= req_sp[grant_id*NODE_W +: NODE_W];
            ep_q     <= req_ep[grant_id*NODE_W +: NODE_W];
            rr_ptr_q <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          end
        end
        LOAD_EP: cnt_q <= '0;
        CPU_RST: cnt_q <= rst_end ? '0 : cnt_q + 32'd1;
        RUN: begin
          cnt_q <= cnt_q + 32'd1;
          if (done_wr) begin
            if (len_ok) begin
              len_q <= LEN_W'(bus.cpu_writedata);
              idx_q <= '0;
            end else begin
              err_q[owner_q] <= 1'b1;
            end
          end else if (timeout_hit) begin
            err_q[owner_q] <= 1'b1;
          end
        end
        STREAM: begin
          if (bus.path_ready) begin
            if (at_last) done_q[owner_q] <= 1'b1;
            else         idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Path buffer contents need no reset; only nodes below len are ever read.
  always_ff @(posedge clk_50M) begin
    if (win_wr) path_buf[path_off[IDX_W+1:2]] <= bus.cpu_writedata[NODE_W-1:0];
  end

endmodule

// File: tb/tb_dijkstra_scheduler.sv
// tb_dijkstra_scheduler: directed bench for dijkstra_scheduler with a scripted
// CPU store model and path consumer; TIMEOUT shortened to 100 cycles.
module tb_dijkstra_scheduler;
  import dijkstra_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int NODE_W     = 5;
  localparam int MAX_PATH   = 32;
  localparam int RST_CYCLES = 4;
  localparam int TIMEOUT    = 100;

  logic        clk_50M = 1'b0;
  logic        rst_n   = 1'b0;
  logic [3:0]  req     = '0;
  logic [19:0] req_sp  = '0;
  logic [19:0] req_ep  = '0;
  logic [3:0]  req_done, req_err;
  logic [1:0]  owner;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int exp_path [8];

  dijkstra_scheduler_if #(.NODE_W(NODE_W)) bus ();

  dijkstra_scheduler #(
    .NUM_REQ(NUM_REQ), .NODE_W(NODE_W), .MAX_PATH(MAX_PATH),
    .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_50M  (clk_50M),
    .rst_n    (rst_n),
    .req      (req),
    .req_sp   (req_sp),
    .req_ep   (req_ep),
    .req_done (req_done),
    .req_err  (req_err),
    .owner    (owner),
    .busy     (busy),
    .bus      (bus)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic cpu_store(input logic [31:0] a, input logic [31:0] d);
    bus.cpu_memwrite  = 1'b1;
    bus.cpu_dataadr   = a;
    bus.cpu_writedata = d;
    step();
    bus.cpu_memwrite  = 1'b0;
  endtask

  task automatic set_nodes(input int id, input int sp, input int ep);
    req_sp[id*5 +: 5] = 5'(sp);
    req_ep[id*5 +: 5] = 5'(ep);
  endtask

  // Follows a grant through LOAD_SP/LOAD_EP/CPU_RST; returns at first RUN cycle.
  task automatic setup_job(input int id, input int sp, input int ep);
    int n;
    n = 0;
    while (bus.cpu_ext_memwrite !== 1'b1 && n < 20) begin step(); n++; end
    chk("grant_wait", 32'(n < 20), 32'd1);
    chk("owner", 32'(owner), 32'(id));
    chk("busy", 32'(busy), 32'd1);
    chk("sp_adr", bus.cpu_ext_dataadr, SP_ADDR);
    chk("sp_dat", bus.cpu_ext_writedata, 32'(sp));
    step();
    chk("ep_we", 32'(bus.cpu_ext_memwrite), 32'd1);
    chk("ep_adr", bus.cpu_ext_dataadr, EP_ADDR);
    chk("ep_dat", bus.cpu_ext_writedata, 32'(ep));
    step();
    n = 0;
    while (bus.cpu_reset === 1'b1 && n < 20) begin step(); n++; end
    chk("rst_cycles", 32'(n), 32'(RST_CYCLES));
    chk("ext_we_off", 32'(bus.cpu_ext_memwrite), 32'd0);
  endtask

  // Path stores (with junk upper bits), stray stores that must be ignored, then DONE.
  task automatic fill_path(input int len);
    for (int i = 0; i < len; i++)
      cpu_store(PATH_BASE + 32'(4 * i), 32'hABC0_0000 | 32'(exp_path[i]));
    cpu_store(PATH_BASE + 32'd1, 32'd31);
    cpu_store(PATH_BASE - 32'd4, 32'd30);
    cpu_store(DONE_ADDR + 32'd4, 32'd29);
    cpu_store(DONE_ADDR, 32'(len));
  endtask

  task automatic expect_stream(input int id, input int len, input bit toggle);
    int idx, cyc;
    idx = 0;
    cyc = 0;
    while (idx < len && cyc < 64) begin
      bus.path_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      chk("valid", 32'(bus.path_valid), 32'd1);
      chk("node", 32'(bus.path_node), 32'(exp_path[idx]));
      chk("last", 32'(bus.path_last), 32'(idx == len - 1));
      chk("stream_owner", 32'(owner), 32'(id));
      chk("no_early_done", 32'(req_done), 32'd0);
      if (bus.path_ready) idx++;
      step();
      cyc++;
    end
    bus.path_ready = 1'b0;
    chk("stream_len", 32'(idx), 32'(len));
    chk("done_pulse", 32'(req_done), 32'(1 << id));
    chk("no_err", 32'(req_err), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(bus.path_valid), 32'd0);
    chk("idle_cpu_rst", 32'(bus.cpu_reset), 32'd1);
  endtask

  task automatic end_job(input int id, input bit drop);
    if (drop) req[id] = 1'b0;
    step();
    chk("pulse_1cyc", 32'(req_done | req_err), 32'd0);
  endtask

  task automatic bad_len(input int id, input int sp, input int ep, input int len);
    setup_job(id, sp, ep);
    cpu_store(DONE_ADDR, 32'(len));
    chk("badlen_err", 32'(req_err), 32'(1 << id));
    chk("badlen_done", 32'(req_done), 32'd0);
    chk("badlen_valid", 32'(bus.path_valid), 32'd0);
    chk("badlen_busy", 32'(busy), 32'd0);
    end_job(id, 1'b1);
  endtask

  initial begin
    int n;
    bus.cpu_memwrite  = 1'b0;
    bus.cpu_dataadr   = '0;
    bus.cpu_writedata = '0;
    bus.path_ready    = 1'b0;
    step();
    step();
    // Reset state
    chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(bus.path_valid), 32'd0);
    chk("rst_ext_we", 32'(bus.cpu_ext_memwrite), 32'd0);
    chk("rst_done", 32'(req_done), 32'd0);
    chk("rst_err", 32'(req_err), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    rst_n = 1'b1;
    step();

    // Single requester 3: path 2 -> 9 -> 17
    set_nodes(3, 2, 17);
    req[3] = 1'b1;
    setup_job(3, 2, 17);
    exp_path[0] = 2; exp_path[1] = 9; exp_path[2] = 17;
    fill_path(3);
    expect_stream(3, 3, 1'b0);
    end_job(3, 1'b1);

    // All four held: round-robin 0,1,2,3,0
    for (int i = 0; i < 4; i++) set_nodes(i, i + 1, i + 10);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      setup_job(k % 4, (k % 4) + 1, (k % 4) + 10);
      exp_path[0] = (k % 4) + 1;
      fill_path(1);
      expect_stream(k % 4, 1, 1'b0);
      if (k == 4) req = 4'b0000;
      end_job(k % 4, 1'b0);
    end

    // Back-pressure: ready toggles 1,0,1,0...
    set_nodes(1, 4, 20);
    req = 4'b0010;
    setup_job(1, 4, 20);
    exp_path[0] = 4; exp_path[1] = 11; exp_path[2] = 20;
    fill_path(3);
    expect_stream(1, 3, 1'b1);
    end_job(1, 1'b1);

    // Timeout: CPU never reports DONE
    req = 4'b0100;
    setup_job(2, 3, 12);
    chk("run_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    n = 0;
    while (req_err === 4'b0000 && n < 300) begin step(); n++; end
    chk("timeout_cycles", 32'(n), 32'(TIMEOUT));
    chk("timeout_err", 32'(req_err), 32'b0100);
    chk("timeout_done", 32'(req_done), 32'd0);
    chk("timeout_cpu_rst", 32'(bus.cpu_reset), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    end_job(2, 1'b1);

    // Invalid lengths 0 and 33
    req = 4'b0001;
    bad_len(0, 1, 10, 0);
    req = 4'b0010;
    bad_len(1, 4, 20, 33);

    // Reset mid-stream, then pointer back at index 0
    req = 4'b0010;
    setup_job(1, 4, 20);
    exp_path[0] = 5; exp_path[1] = 6; exp_path[2] = 7;
    fill_path(3);
    bus.path_ready = 1'b1;
    chk("pre_rst_node0", 32'(bus.path_node), 32'd5);
    step();
    chk("pre_rst_node1", 32'(bus.path_node), 32'd6);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.path_valid), 32'd0);
    chk("arst_node", 32'(bus.path_node), 32'd0);
    chk("arst_last", 32'(bus.path_last), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("arst_owner", 32'(owner), 32'd0);
    chk("arst_pulses", 32'(req_done | req_err), 32'd0);
    bus.path_ready = 1'b0;
    req = 4'b0000;
    step();
    chk("arst_held_pulses", 32'(req_done | req_err), 32'd0);
    rst_n = 1'b1;
    set_nodes(0, 1, 10);
    req = 4'b1001;
    setup_job(0, 1, 10);
    exp_path[0] = 1;
    fill_path(1);
    expect_stream(0, 1, 1'b0);
    req = 4'b0000;
    end_job(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
